mem: RTL
========

# mem

Memory-access stage of the five-stage pipeline, sitting between the EX/MEM pipeline register and `mem_wb`. It decodes load/store ops, drives a request/acknowledge data bus with big-endian byte lanes, and aligns and extends load data. While an access is in flight it holds the pipeline via `stallreq`, and it aborts on bus timeout. Results, including HI/LO passthrough, go straight into `mem_wb`'s `mem_*` inputs.

## Interface
- `TIMEOUT`, default 255, is the number of WAIT cycles without `bus_ack` before the access is aborted. Legal range is 1..65535.
- `clk` in 1: pipeline clock; all state changes on the rising edge.
- `rst` in 1: reset. **One clock; reset is asynchronous and active-high.**
- `ex_wd` in 5: destination register address.
- `ex_wreg` in 1: GPR write enable.
- `ex_wdata` in 32: ALU result.
- `ex_hi`, `ex_lo` in 32 each: HI/LO write data.
- `ex_whilo` in 1: HI/LO write enable.
- `ex_mem_op` in 4: memory op code.
  - 0 = NONE, 1 = LB, 2 = LBU, 3 = LH, 4 = LHU, 5 = LW.
  - 9 = SB, A = SH, B = SW.
  - All other codes are treated as NONE.
- `ex_mem_addr` in 32: effective address.
- `ex_reg2` in 32: store data.
- `mem_wd` out 5, `mem_wreg` out 1, `mem_wdata` out 32: GPR result to `mem_wb`.
- `mem_hi`, `mem_lo` out 32, `mem_whilo` out 1: HI/LO result to `mem_wb`.
- `stallreq` out 1: pipeline hold request to the stall controller.
- `misalign` out 1: current op is misaligned (combinational).
- `bus_err` out 1: one-cycle pulse on timeout abort.
- `bus_req` out 1, `bus_we` out 1, `bus_addr` out 32, `bus_sel` out 4, `bus_wdata` out 32: registered bus request outputs.
- `bus_rdata` in 32, `bus_ack` in 1: bus response.

## Operation
- **Reset values.**
  - FSM state is IDLE.
  - `bus_req`, `bus_we`, `bus_addr`, `bus_sel`, `bus_wdata`, `bus_err`, the load-data register and the timeout counter are all 0.
  - While `rst` is high, all combinational outputs are 0.
- **Passthrough.** `mem_hi`/`mem_lo`/`mem_whilo` always equal `ex_hi`/`ex_lo`/`ex_whilo`, and `mem_wd` = `ex_wd`.
- **NONE op.** `mem_wreg` = `ex_wreg`, `mem_wdata` = `ex_wdata`, `stallreq` = 0.
- **Alignment.**
  - LH/LHU/SH are misaligned if `addr[0]`=1.
  - LW/SW are misaligned if `addr[1:0]`≠0.
  - A misaligned op raises `misalign`, forces `mem_wreg`=0, makes no bus access and does not stall.
- **Byte lanes (big-endian).**
  - Byte op: `addr[1:0]` 00/01/10/11 selects `sel` 1000/0100/0010/0001, i.e. `rdata[31:24]`, `[23:16]`, `[15:8]`, `[7:0]` respectively.
  - Halfword op: `addr[1]` 0/1 selects `sel` 1100/0011, i.e. `rdata[31:16]` / `[15:0]`.
  - Word op: `sel` 1111.
  - `bus_addr` = `{addr[31:2], 2'b00}`.
  - Store data is replicated across lanes: SB = `{4{reg2[7:0]}}`, SH = `{2{reg2[15:0]}}`, SW = `reg2`.
- **Extension.** LB and LH sign-extend; LBU and LHU zero-extend.
- **FSM states:** IDLE, WAIT, DONE.
  - **IDLE.** For an aligned load/store: `stallreq`=1 and `mem_wreg`=0. On the next edge, latch `bus_addr`/`sel`/`we`/`wdata`, set `bus_req`=1, clear the counter and go to WAIT.
  - **WAIT.** `stallreq`=1 and `mem_wreg`=0.
    - If `bus_ack`=1: capture the aligned/extended load data, drop `bus_req`/`bus_we`, go to DONE.
    - Otherwise, if counter = `TIMEOUT`-1: drop `bus_req`, pulse `bus_err` for the first DONE cycle, go to DONE with the abort flag set.
    - Otherwise increment the counter.
    - `bus_ack` on the timeout cycle counts as success; ack wins.
  - **DONE.** `stallreq`=0.
    - Load: `mem_wreg` = `ex_wreg` and `mem_wdata` = the captured data, unless aborted, in which case `mem_wreg`=0.
    - Store: `mem_wreg`=0.
    - Always return to IDLE on the next edge.
- **Ignored ack.** `bus_ack` in IDLE or DONE has no effect.
- **Reset mid-access.** `bus_req` drops immediately (asynchronously) and the FSM returns to IDLE; the access is lost.

## Timing
- Inputs must be held stable while `stallreq`=1. `stallreq` feeds the stall controller, which holds EX/MEM (`stall[3]`) and bubbles `mem_wb`.
- NONE and misaligned ops: zero extra latency.
- Aligned access with ack in the first WAIT cycle:
  - IDLE cycle: `stallreq`=1.
  - WAIT cycle: `bus_req`=1, `bus_ack`=1.
  - DONE cycle: result valid and `mem_wb` captures it.
  - Minimum cost is 2 stall cycles; each extra WAIT cycle adds one.
- Timeout: `bus_req` is high for exactly `TIMEOUT` cycles, then DONE.
- Back-to-back accesses: DONE → IDLE detects the next op on the following cycle, so `bus_req` is low for at least 2 cycles between accesses.

## Test plan
- **LW, immediate ack.** LW `addr`=0x100, `rdata`=0x11223344, `ack` in first WAIT → `bus_sel`=1111, `stallreq` high for 2 cycles, then `mem_wdata`=0x11223344 with `mem_wreg`=1.
- **Byte/halfword loads.** With `rdata`=0x80FF7F01:
  - LB `addr`=0x101 → `sel` 0100, result 0xFFFFFFFF.
  - LBU `addr`=0x100 → 0x00000080.
  - LH `addr`=0x102 → 0x00007F01.
  - LHU `addr`=0x100 → 0x000080FF.
- **Stores.** SB `addr`=0x203 with `reg2`=0xDEADBEEF → `bus_we`=1, `sel` 0001, `bus_wdata`=0xEFEFEFEF, `mem_wreg`=0. SH `addr`=0x202 → `sel` 0011, `wdata`=0xBEEFBEEF.
- **Misalignment.** LW `addr`=0x101 → `misalign`=1, `bus_req` never asserted, `stallreq`=0, `mem_wreg`=0.
- **Timeout.** `TIMEOUT`=4, ack never arrives → `bus_req` high 4 cycles, `bus_err` pulses 1 cycle, `mem_wreg`=0. Repeat with ack on the 4th WAIT cycle → normal completion with no `bus_err`.
- **Reset and NONE passthrough.** Assert `rst` mid-WAIT → `bus_req`=0 immediately, and the FSM is in IDLE after release. A NONE op passes `ex_wdata`=0x12345678, `ex_whilo`=1 and HI/LO unchanged with `stallreq`=0.

Source files
------------

// File: rtl/mem.sv
// Memory-access stage of the five-stage pipeline.
// Decodes load/store ops, runs a req/ack data bus with big-endian byte lanes,
// aligns and extends load data, and holds the pipeline while an access is in flight.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   ex_*                          EX/MEM pipeline register contents
//   mem_*                         results to mem_wb (GPR and HI/LO)
//   stallreq                      hold request to the stall controller
//   misalign                      current op is misaligned (combinational)
//   bus_err                       one-cycle pulse when an access times out
//   bus_req/we/addr/sel/wdata     registered bus request
//   bus_rdata, bus_ack            bus response
module mem #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic        ex_whilo,
    input  logic [3:0]  ex_mem_op,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_reg2,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        mem_whilo,
    output logic        stallreq,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;
    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

    localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

    state_e      state_q;
    logic [15:0] cnt_q;
    logic [31:0] load_q;
    logic        abort_q;

    logic        is_load, is_store, sign_ext, mis_al, access;
    size_e       size;
    logic [3:0]  lane_sel;
    logic [31:0] st_data, ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Op decode; undefined codes fall through as NONE.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sign_ext = 1'b0;
        size     = SzWord;
        case (ex_mem_op)
            4'h1: begin is_load = 1'b1; size = SzByte; sign_ext = 1'b1; end
            4'h2: begin is_load = 1'b1; size = SzByte; end
            4'h3: begin is_load = 1'b1; size = SzHalf; sign_ext = 1'b1; end
            4'h4: begin is_load = 1'b1; size = SzHalf; end
            4'h5: begin is_load = 1'b1; size = SzWord; end
            4'h9: begin is_store = 1'b1; size = SzByte; end
            4'hA: begin is_store = 1'b1; size = SzHalf; end
            4'hB: begin is_store = 1'b1; size = SzWord; end
            default: ;
        endcase
    end

    always_comb begin
        mis_al = 1'b0;
        if (is_load || is_store) begin
            if (size == SzHalf) mis_al = ex_mem_addr[0];
            if (size == SzWord) mis_al = (ex_mem_addr[1:0] != 2'b00);
        end
        access = (is_load || is_store) && !mis_al;
    end

    // Big-endian lanes: byte 0 of the word lives in bits [31:24].
    always_comb begin
        lane_sel = 4'b1111;
        st_data  = ex_reg2;
        case (size)
            SzByte: begin
                lane_sel = 4'b1000 >> ex_mem_addr[1:0];
                st_data  = {4{ex_reg2[7:0]}};
            end
            SzHalf: begin
                lane_sel = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
                st_data  = {2{ex_reg2[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ex_mem_addr[1:0])
            2'b00:   ld_byte = bus_rdata[31:24];
            2'b01:   ld_byte = bus_rdata[23:16];
            2'b10:   ld_byte = bus_rdata[15:8];
            default: ld_byte = bus_rdata[7:0];
        endcase
        ld_half = ex_mem_addr[1] ? bus_rdata[15:0] : bus_rdata[31:16];
        case (size)
            SzByte:  ld_data = {{24{sign_ext & ld_byte[7]}}, ld_byte};
            SzHalf:  ld_data = {{16{sign_ext & ld_half[15]}}, ld_half};
            default: ld_data = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 16'd0;
            load_q    <= 32'd0;
            abort_q   <= 1'b0;
            bus_err   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_sel   <= 4'd0;
            bus_wdata <= 32'd0;
        end else begin
            bus_err <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (access) begin
                        bus_addr  <= {ex_mem_addr[31:2], 2'b00};
                        bus_sel   <= lane_sel;
                        bus_we    <= is_store;
                        bus_wdata <= st_data;
                        bus_req   <= 1'b1;
                        cnt_q     <= 16'd0;
                        abort_q   <= 1'b0;
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    // Ack on the last counted cycle still completes normally.
                    if (bus_ack) begin
                        load_q  <= ld_data;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        state_q <= StDone;
                    end else if (cnt_q == CntLast) begin
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        bus_err <= 1'b1;
                        abort_q <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        mem_wd    = ex_wd;
        mem_hi    = ex_hi;
        mem_lo    = ex_lo;
        mem_whilo = ex_whilo;
        mem_wreg  = ex_wreg;
        mem_wdata = ex_wdata;
        misalign  = mis_al;
        stallreq  = 1'b0;
        case (state_q)
            StIdle: begin
                if (is_load || is_store) begin
                    mem_wreg = 1'b0;
                    stallreq = access;
                end
            end
            StWait: begin
                mem_wreg = 1'b0;
                stallreq = 1'b1;
            end
            StDone: begin
                if (is_load || is_store) begin
                    mem_wreg = 1'b0;
                    if (is_load && !mis_al && !abort_q) begin
                        mem_wreg  = ex_wreg;
                        mem_wdata = load_q;
                    end
                end
            end
            default: ;
        endcase
        if (rst) begin
            mem_wd    = 5'd0;
            mem_hi    = 32'd0;
            mem_lo    = 32'd0;
            mem_whilo = 1'b0;
            mem_wreg  = 1'b0;
            mem_wdata = 32'd0;
            misalign  = 1'b0;
            stallreq  = 1'b0;
        end
    end

endmodule
